uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive-side stage that consumes the serial line driven by the UART transmitter's TX_OUT.
//  Frame format is identical to TX: start(0), WIDTH data bits LSB-first, optional parity, stop(1).
//  Line is oversampled PRESCALE times per bit with a 3-sample majority vote.
//  A recovered byte goes to the bus side with a one-cycle valid pulse and error flags.
// PARAMETERS
//  WIDTH     8   data bits per frame
//  PRESCALE  8   clk cycles per serial bit; legal values are 8, 16 or 32
// PORTS
//  clk       in   1      receive clock (PRESCALE x TX bit rate)
//  rst       in   1      asynchronous, active-low reset
//  RX_IN     in   1      serial line; idle high; asynchronous to clk
//  par_en    in   1      1 = frame carries a parity bit
//  PAR_TYP   in   1      0 = even, 1 = odd parity
//  P_DATA    out  WIDTH  received data; holds its value until the next good frame
//  data_valid out 1      one-cycle pulse; P_DATA is valid
//  par_err   out  1      one-cycle pulse; parity mismatch
//  stp_err   out  1      one-cycle pulse; stop bit sampled as 0
// BEHAVIOUR
//  Reset (rst=0, async): all outputs are 0, P_DATA=0, FSM=IDLE, counters=0, sync flops=1.
//  Input sync: RX_IN passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized rx_s.
//  Counters:
//   - edge_cnt runs 0..PRESCALE-1 and wraps to 0 at each bit boundary.
//   - bit_cnt counts data bits 0..WIDTH-1.
//  Sampling: rx_s is captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
//   The bit value is the majority of the three, decided at PRESCALE/2+1.
//  FSM states:
//   - IDLE: a falling rx_s (prev 1, now 0) -> START with edge_cnt=0. par_en/PAR_TYP are latched here and used for the whole frame.
//   - START: if the majority = 1, it is a glitch: -> IDLE with no flags. Otherwise at edge_cnt wrap -> DATA.
//   - DATA: shift the majority into shift_reg[bit_cnt] (LSB first). After bit WIDTH-1 wraps: -> PARITY if par_en latched, else -> STOP.
//   - PARITY: compute the expected parity over shift_reg (even: ^data; odd: ~^data) and compare it with the majority.
//     A mismatch sets the internal perr. At wrap -> STOP.
//   - STOP: decided at PRESCALE/2+1, then -> IDLE immediately (mid-stop), so the next start edge is caught.
//     - Stop=1 and !perr: next cycle data_valid=1 and P_DATA<=shift_reg.
//     - Stop=1 and perr: next cycle par_err=1; P_DATA unchanged.
//     - Stop=0: next cycle stp_err=1 (par_err is also set if perr); P_DATA unchanged, data_valid=0.
//  Latency: sync (2) + mid-bit sampling. data_valid rises 2+PRESCALE/2+2 clks after the RX_IN stop-bit edge.
//  Simultaneous events: these flag pulses are never extended. A new start edge during the flag cycle is still detected.
//  Back-to-back frames with no idle gap are received without loss.
//  RX_IN held low (break): the frame ends with stp_err. The FSM then waits in IDLE for a 1->0 edge and does not re-trigger on a constant 0.
//  par_en/PAR_TYP changes mid-frame have no effect until the next start.
//  Reset mid-frame: immediate return to IDLE; no flag pulses; P_DATA cleared.
// TESTING
//  1 WIDTH=8, PRESCALE=8, par_en=0, send 0xA5 -> exactly one data_valid pulse, P_DATA=0xA5, no errors.
//  2 par_en=1, PAR_TYP=0, send 0x3C with parity bit 0 -> data_valid, P_DATA=0x3C.
//    Repeat with parity bit 1 -> par_err pulse, no data_valid, P_DATA still 0x3C.
//  3 send 0x55 with stop bit forced 0 -> stp_err pulse, no data_valid, FSM back in IDLE.
//    A following good 0x0F frame -> P_DATA=0x0F.
//  4 RX_IN low for 2 clks, then high -> no flags, FSM returns to IDLE (glitch reject).
//    Then a 1-clk low spike inside a data bit at edge_cnt=PRESCALE/2 -> majority keeps the bit value.
//  5 three back-to-back frames 0x01,0x80,0xFF with no idle gap, PRESCALE=16, par_en=1, PAR_TYP=1 -> three data_valid pulses in order, no errors.
//  6 rst=0 asserted in the middle of data bit 4 -> outputs 0 at once.
//    After release, a clean 0x7E frame -> P_DATA=0x7E, data_valid once.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, PRESCALE-times oversampling with a
// 3-sample majority vote around mid-bit, optional even/odd parity, stop check.
module uart_rx #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic             par_en,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_C    = CW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q,    rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  state_t           state_q,   state_d;
  logic [CW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic             smp_a_q,   smp_a_d;
  logic             smp_b_q,   smp_b_d;
  logic             perr_q,    perr_d;
  logic             pen_q,     pen_d;
  logic             ptyp_q,    ptyp_d;
  logic [WIDTH-1:0] p_data_q,  p_data_d;
  logic             dv_q,      dv_d;
  logic             pe_q,      pe_d;
  logic             se_q,      se_d;

  logic at_dec;
  logic at_wrap;
  logic bit_val;

  assign at_dec  = (edge_cnt_q == SMP_C);
  assign at_wrap = (edge_cnt_q == CNT_LAST);
  assign bit_val = maj3(smp_a_q, smp_b_q, rx_s_q);

  always_comb begin
    rx_meta_d  = RX_IN;
    rx_s_d     = rx_meta_q;
    rx_prev_d  = rx_s_q;
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    smp_a_d    = smp_a_q;
    smp_b_d    = smp_b_q;
    perr_d     = perr_q;
    pen_d      = pen_q;
    ptyp_d     = ptyp_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + CW'(1);
      if (edge_cnt_q == SMP_A) smp_a_d = rx_s_q;
      if (edge_cnt_q == SMP_B) smp_b_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        // The cycle that sees the falling edge is sample 0 of the start bit,
        // so the first START cycle already counts 1.
        if (rx_prev_q && !rx_s_q) begin
          state_d    = START;
          edge_cnt_d = CW'(1);
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          pen_d      = par_en;
          ptyp_d     = PAR_TYP;
        end
      end
      START: begin
        if (at_dec && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (at_wrap) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (at_dec) shift_d[bit_cnt_q] = bit_val;
        if (at_wrap) begin
          if (bit_cnt_q == BIT_LAST) state_d = pen_q ? PARITY : STOP;
          else                       bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      PARITY: begin
        if (at_dec) perr_d = (bit_val != exp_parity(shift_q, ptyp_q));
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (at_dec) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          if (bit_val) begin
            if (perr_q) begin
              pe_d = 1'b1;
            end else begin
              dv_d     = 1'b1;
              p_data_d = shift_q;
            end
          end else begin
            se_d = 1'b1;
            pe_d = perr_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      smp_a_q    <= 1'b1;
      smp_b_q    <= 1'b1;
      perr_q     <= 1'b0;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      smp_a_q    <= smp_a_d;
      smp_b_q    <= smp_b_d;
      perr_q     <= perr_d;
      pen_q      <= pen_d;
      ptyp_q     <= ptyp_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at PRESCALE=8 and one at PRESCALE=16, serial
// frames built from bytes and compared against an expected-result model.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx8 = 1'b1, pen8 = 1'b0, ptyp8 = 1'b0;
  logic rx16 = 1'b1, pen16 = 1'b0, ptyp16 = 1'b0;
  logic [7:0] pdata8, pdata16;
  logic dv8_o, pe8_o, se8_o, dv16_o, pe16_o, se16_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int dv_cyc8 = 0;
  int n_dv8 = 0, n_pe8 = 0, n_se8 = 0;
  int n_dv16 = 0, n_pe16 = 0, n_se16 = 0;
  logic [7:0] q16[$];

  uart_rx #(.WIDTH(8), .PRESCALE(8)) dut8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .par_en(pen8), .PAR_TYP(ptyp8),
    .P_DATA(pdata8), .data_valid(dv8_o), .par_err(pe8_o), .stp_err(se8_o)
  );

  uart_rx #(.WIDTH(8), .PRESCALE(16)) dut16 (
    .clk(clk), .rst(rst), .RX_IN(rx16), .par_en(pen16), .PAR_TYP(ptyp16),
    .P_DATA(pdata16), .data_valid(dv16_o), .par_err(pe16_o), .stp_err(se16_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv8_o) begin n_dv8++; dv_cyc8 = cyc; end
    if (pe8_o) n_pe8++;
    if (se8_o) n_se8++;
    if (dv16_o) begin n_dv16++; q16.push_back(pdata16); end
    if (pe16_o) n_pe16++;
    if (se16_o) n_se16++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx8 = 1'b1;
    rx16 = 1'b1;
    repeat (n) tick();
  endtask

  // Parity bit that makes the frame correct: even -> total ones even.
  function automatic logic good_par(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input int which, input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit,
                            input int spike_bit, input int abort_bit);
    int n;
    int nb;
    logic [11:0] bits;
    logic v;
    n = (which == 16) ? 16 : 8;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (with_par) begin bits[nb] = par_bit; nb++; end
    bits[nb] = stop_bit;
    nb++;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < n; c++) begin
        v = bits[j];
        if (j == spike_bit && c == n / 2) v = 1'b0;
        if (j == nb - 1 && c == 0) stop_cyc = cyc;
        if (which == 16) rx16 = v; else rx8 = v;
        if (j == abort_bit && c == n / 2) return;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (pdata8 !== 8'h00) begin bad++; $display("FAIL reset_pdata8 got=%h want=00", pdata8); end
    total++; if ({dv8_o, pe8_o, se8_o} !== 3'b000) begin bad++; $display("FAIL reset_flags8 got=%b want=000", {dv8_o, pe8_o, se8_o}); end
    total++; if (pdata16 !== 8'h00) begin bad++; $display("FAIL reset_pdata16 got=%h want=00", pdata16); end
    rst = 1'b1;
    idle(32);
    total++; if (n_dv8 + n_pe8 + n_se8 !== 0) begin bad++; $display("FAIL reset_idle_flags got=%0d want=0", n_dv8 + n_pe8 + n_se8); end
  endtask

  task automatic test_basic();
    int b_dv;
    logic [7:0] d;
    logic pe, pt;
    pen8 = 1'b0;
    b_dv = n_dv8;
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(16);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL basic_dv_count got=%0d want=1", n_dv8 - b_dv); end
    total++; if (pdata8 !== 8'hA5) begin bad++; $display("FAIL basic_pdata got=%h want=a5", pdata8); end
    total++; if (dv_cyc8 - stop_cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", dv_cyc8 - stop_cyc); end
    total++; if (n_pe8 + n_se8 !== 0) begin bad++; $display("FAIL basic_errs got=%0d want=0", n_pe8 + n_se8); end
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pen8 = pe;
      ptyp8 = pt;
      b_dv = n_dv8;
      send_frame(8, d, pe, good_par(d, pt), 1'b1, -1, -1);
      idle(12);
      total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL rand_dv_count got=%0d want=1", n_dv8 - b_dv); end
      total++; if (pdata8 !== d) begin bad++; $display("FAIL rand_pdata got=%h want=%h", pdata8, d); end
    end
    total++; if (n_pe8 + n_se8 !== 0) begin bad++; $display("FAIL rand_errs got=%0d want=0", n_pe8 + n_se8); end
  endtask

  task automatic test_parity();
    int b_dv, b_pe, b_se;
    pen8 = 1'b1;
    ptyp8 = 1'b0;
    b_dv = n_dv8;
    send_frame(8, 8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
    idle(12);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL par_good_dv got=%0d want=1", n_dv8 - b_dv); end
    total++; if (pdata8 !== 8'h3C) begin bad++; $display("FAIL par_good_pdata got=%h want=3c", pdata8); end
    b_dv = n_dv8; b_pe = n_pe8; b_se = n_se8;
    send_frame(8, 8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
    idle(12);
    total++; if (n_pe8 - b_pe !== 1) begin bad++; $display("FAIL par_bad_pe got=%0d want=1", n_pe8 - b_pe); end
    total++; if (n_dv8 - b_dv !== 0) begin bad++; $display("FAIL par_bad_dv got=%0d want=0", n_dv8 - b_dv); end
    total++; if (n_se8 - b_se !== 0) begin bad++; $display("FAIL par_bad_se got=%0d want=0", n_se8 - b_se); end
    total++; if (pdata8 !== 8'h3C) begin bad++; $display("FAIL par_bad_pdata got=%h want=3c", pdata8); end
    // Odd parity with a wrong bit
    ptyp8 = 1'b1;
    b_pe = n_pe8;
    send_frame(8, 8'h96, 1'b1, ~good_par(8'h96, 1'b1), 1'b1, -1, -1);
    idle(12);
    total++; if (n_pe8 - b_pe !== 1) begin bad++; $display("FAIL par_odd_pe got=%0d want=1", n_pe8 - b_pe); end
    // Settings changed mid-frame must not affect the frame in flight
    ptyp8 = 1'b0;
    b_dv = n_dv8; b_pe = n_pe8;
    fork
      send_frame(8, 8'hC1, 1'b1, good_par(8'hC1, 1'b0), 1'b1, -1, -1);
      begin repeat (24) tick(); pen8 = 1'b0; ptyp8 = 1'b1; end
    join
    idle(12);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL par_latch_dv got=%0d want=1", n_dv8 - b_dv); end
    total++; if (n_pe8 - b_pe !== 0) begin bad++; $display("FAIL par_latch_pe got=%0d want=0", n_pe8 - b_pe); end
    total++; if (pdata8 !== 8'hC1) begin bad++; $display("FAIL par_latch_pdata got=%h want=c1", pdata8); end
  endtask

  task automatic test_stop_err();
    int b_dv, b_pe, b_se;
    pen8 = 1'b0;
    b_dv = n_dv8; b_se = n_se8;
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(16);
    total++; if (n_se8 - b_se !== 1) begin bad++; $display("FAIL stop_se got=%0d want=1", n_se8 - b_se); end
    total++; if (n_dv8 - b_dv !== 0) begin bad++; $display("FAIL stop_dv got=%0d want=0", n_dv8 - b_dv); end
    total++; if (pdata8 !== 8'hC1) begin bad++; $display("FAIL stop_pdata_hold got=%h want=c1", pdata8); end
    b_dv = n_dv8;
    send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(12);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL stop_next_dv got=%0d want=1", n_dv8 - b_dv); end
    total++; if (pdata8 !== 8'h0F) begin bad++; $display("FAIL stop_next_pdata got=%h want=0f", pdata8); end
    // Stop error together with a parity error flags both
    pen8 = 1'b1;
    ptyp8 = 1'b0;
    b_pe = n_pe8; b_se = n_se8; b_dv = n_dv8;
    send_frame(8, 8'h01, 1'b1, 1'b0, 1'b0, -1, -1);
    idle(16);
    total++; if ({n_pe8 - b_pe, n_se8 - b_se, n_dv8 - b_dv} !== {32'sd1, 32'sd1, 32'sd0}) begin
      bad++; $display("FAIL stop_par_both got=pe%0d se%0d dv%0d want=pe1 se1 dv0", n_pe8 - b_pe, n_se8 - b_se, n_dv8 - b_dv);
    end
    pen8 = 1'b0;
  endtask

  task automatic test_glitch();
    int b_dv, b_pe, b_se;
    logic [7:0] d;
    b_dv = n_dv8; b_pe = n_pe8; b_se = n_se8;
    rx8 = 1'b0;
    tick();
    tick();
    idle(32);
    total++; if (n_dv8 + n_pe8 + n_se8 - b_dv - b_pe - b_se !== 0) begin
      bad++; $display("FAIL glitch_flags got=%0d want=0", n_dv8 + n_pe8 + n_se8 - b_dv - b_pe - b_se);
    end
    d = 8'($urandom) | 8'h08;
    b_dv = n_dv8;
    send_frame(8, d, 1'b0, 1'b0, 1'b1, 4, -1);
    idle(12);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL spike_dv got=%0d want=1", n_dv8 - b_dv); end
    total++; if (pdata8 !== d) begin bad++; $display("FAIL spike_pdata got=%h want=%h", pdata8, d); end
  endtask

  task automatic test_break();
    int b_dv, b_pe, b_se;
    logic [7:0] d;
    pen8 = 1'b0;
    b_dv = n_dv8; b_pe = n_pe8; b_se = n_se8;
    rx8 = 1'b0;
    repeat (240) tick();
    idle(16);
    total++; if (n_se8 - b_se !== 1) begin bad++; $display("FAIL break_se got=%0d want=1", n_se8 - b_se); end
    total++; if (n_dv8 - b_dv + n_pe8 - b_pe !== 0) begin bad++; $display("FAIL break_other got=%0d want=0", n_dv8 - b_dv + n_pe8 - b_pe); end
    d = 8'($urandom) | 8'h01;
    b_dv = n_dv8;
    send_frame(8, d, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(12);
    total++; if (pdata8 !== d || n_dv8 - b_dv !== 1) begin
      bad++; $display("FAIL break_recover got=%h/%0d want=%h/1", pdata8, n_dv8 - b_dv, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int b_pe, b_se;
    pen16 = 1'b1;
    ptyp16 = 1'b1;
    q16.delete();
    b_pe = n_pe16; b_se = n_se16;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 3; k++) exp_q.push_back(8'($urandom));
    for (int k = 0; k < exp_q.size(); k++) begin
      d = exp_q[k];
      send_frame(16, d, 1'b1, good_par(d, 1'b1), 1'b1, -1, -1);
    end
    idle(40);
    total++; if (q16.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", q16.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q16.size(); k++) begin
      total++; if (q16[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, q16[k], exp_q[k]); end
    end
    total++; if (n_pe16 - b_pe + n_se16 - b_se !== 0) begin bad++; $display("FAIL b2b_errs got=%0d want=0", n_pe16 - b_pe + n_se16 - b_se); end
  endtask

  task automatic test_reset_mid();
    int b_dv, b_pe, b_se;
    pen8 = 1'b0;
    b_dv = n_dv8; b_pe = n_pe8; b_se = n_se8;
    send_frame(8, 8'hE7, 1'b0, 1'b0, 1'b1, -1, 5);
    #2;
    rst = 1'b0;
    #1;
    total++; if (pdata8 !== 8'h00) begin bad++; $display("FAIL rstmid_pdata got=%h want=00", pdata8); end
    total++; if ({dv8_o, pe8_o, se8_o} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b want=000", {dv8_o, pe8_o, se8_o}); end
    rx8 = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    idle(24);
    total++; if (n_dv8 + n_pe8 + n_se8 - b_dv - b_pe - b_se !== 0) begin
      bad++; $display("FAIL rstmid_no_flags got=%0d want=0", n_dv8 + n_pe8 + n_se8 - b_dv - b_pe - b_se);
    end
    b_dv = n_dv8;
    send_frame(8, 8'h7E, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(12);
    total++; if (n_dv8 - b_dv !== 1) begin bad++; $display("FAIL rstmid_dv got=%0d want=1", n_dv8 - b_dv); end
    total++; if (pdata8 !== 8'h7E) begin bad++; $display("FAIL rstmid_pdata_after got=%h want=7e", pdata8); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
